// File: rtl/sram22_ctrl_pkg.sv
// Shared types and default widths for the dual-requester SRAM22 controller.
// Optional read-path register stage is selected with SRAM22_RDATA_REG_EN.
package sram22_ctrl_pkg;

  localparam int DEF_ADDR_WIDTH  = 9;
  localparam int DEF_DATA_WIDTH  = 64;
  localparam int DEF_WMASK_WIDTH = 8;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  // Grant vector layout: bit 0 = requester A, bit 1 = requester B.
  function automatic logic [1:0] id_to_onehot(input req_id_e id);
    logic [1:0] oh;
    case (id)
      REQ_A:   oh = 2'b01;
      REQ_B:   oh = 2'b10;
      default: oh = 2'b00;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/sram22_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the requester that wins a tie
// and moves to the loser after every grant.
module sram22_rr_arb2
  import sram22_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rstb,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  req_id_e ptr_q, ptr_d;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = id_to_onehot(ptr_q);
        default: grant = 2'b00;
      endcase
    end else begin
      grant = 2'b00;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    case (grant)
      2'b01:   ptr_d = REQ_B;
      2'b10:   ptr_d = REQ_A;
      default: ptr_d = ptr_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      ptr_q <= REQ_A;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/sram22_dual_req_ctrl.sv
// Shares one single-port SRAM22 macro between requesters A and B after a zero-fill.
// Define SRAM22_RDATA_REG_EN to add a register stage on the read-response path.
module sram22_dual_req_ctrl
  import sram22_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int WMASK_WIDTH = DEF_WMASK_WIDTH
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic                   a_valid,
  output logic                   a_ready,
  input  logic                   a_we,
  input  logic [WMASK_WIDTH-1:0] a_wmask,
  input  logic [ADDR_WIDTH-1:0]  a_addr,
  input  logic [DATA_WIDTH-1:0]  a_din,
  output logic                   a_rvalid,
  output logic [DATA_WIDTH-1:0]  a_rdata,
  input  logic                   b_valid,
  output logic                   b_ready,
  input  logic                   b_we,
  input  logic [WMASK_WIDTH-1:0] b_wmask,
  input  logic [ADDR_WIDTH-1:0]  b_addr,
  input  logic [DATA_WIDTH-1:0]  b_din,
  output logic                   b_rvalid,
  output logic [DATA_WIDTH-1:0]  b_rdata,
  output logic                   init_done,
  output logic                   sram_rstb,
  output logic                   sram_ce,
  output logic                   sram_we,
  output logic [WMASK_WIDTH-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_din,
  input  logic [DATA_WIDTH-1:0]  sram_dout
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    init_done_q, init_done_d;
  logic [1:0]              grant_s;
  logic                    arb_en_s;
  logic                    rd_a_s, rd_b_s;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == LAST_ADDR) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end else begin
          state_d     = ST_INIT;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d     = ST_INIT;
        cnt_d       = {ADDR_WIDTH{1'b0}};
        init_done_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q     <= ST_INIT;
      cnt_q       <= {ADDR_WIDTH{1'b0}};
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
    end
  end

  // Requests are only seen once the fill is over and reset is released.
  assign arb_en_s = rstb & (state_q == ST_RUN);

  sram22_rr_arb2 u_arb (
    .clk   (clk),
    .rstb  (rstb),
    .en    (arb_en_s),
    .valid ({b_valid, a_valid}),
    .grant (grant_s)
  );

  assign a_ready   = grant_s[0];
  assign b_ready   = grant_s[1];
  assign init_done = init_done_q;
  assign sram_rstb = rstb;

  always_comb begin
    sram_ce    = 1'b0;
    sram_we    = 1'b0;
    sram_wmask = {WMASK_WIDTH{1'b0}};
    sram_addr  = {ADDR_WIDTH{1'b0}};
    sram_din   = {DATA_WIDTH{1'b0}};
    if (!rstb) begin
      sram_ce = 1'b0;
    end else if (state_q == ST_INIT) begin
      sram_ce    = 1'b1;
      sram_we    = 1'b1;
      sram_wmask = {WMASK_WIDTH{1'b1}};
      sram_addr  = cnt_q;
    end else if (grant_s[0]) begin
      sram_ce    = 1'b1;
      sram_we    = a_we;
      sram_wmask = a_wmask;
      sram_addr  = a_addr;
      sram_din   = a_din;
    end else if (grant_s[1]) begin
      sram_ce    = 1'b1;
      sram_we    = b_we;
      sram_wmask = b_wmask;
      sram_addr  = b_addr;
      sram_din   = b_din;
    end else begin
      sram_ce = 1'b0;
    end
  end

  assign rd_a_s = grant_s[0] & ~a_we;
  assign rd_b_s = grant_s[1] & ~b_we;

`ifdef SRAM22_RDATA_REG_EN
  // Stage 1 tags the cycle the macro presents data; stage 2 registers it.
  logic                  tag_a_q, tag_b_q;
  logic                  a_rvalid_q, b_rvalid_q;
  logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

  always_comb begin
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    if (tag_a_q) begin
      a_rdata_d = sram_dout;
    end else begin
      a_rdata_d = a_rdata_q;
    end
    if (tag_b_q) begin
      b_rdata_d = sram_dout;
    end else begin
      b_rdata_d = b_rdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      tag_a_q    <= 1'b0;
      tag_b_q    <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= {DATA_WIDTH{1'b0}};
      b_rdata_q  <= {DATA_WIDTH{1'b0}};
    end else begin
      tag_a_q    <= rd_a_s;
      tag_b_q    <= rd_b_s;
      a_rvalid_q <= tag_a_q;
      b_rvalid_q <= tag_b_q;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;
`else
  // Macro output is already registered, so data passes straight through in the
  // response cycle and a holding register keeps it stable afterwards.
  logic                  a_rvalid_q, b_rvalid_q;
  logic [DATA_WIDTH-1:0] a_hold_q, a_hold_d, b_hold_q, b_hold_d;

  always_comb begin
    a_hold_d = a_hold_q;
    b_hold_d = b_hold_q;
    if (a_rvalid_q) begin
      a_hold_d = sram_dout;
    end else begin
      a_hold_d = a_hold_q;
    end
    if (b_rvalid_q) begin
      b_hold_d = sram_dout;
    end else begin
      b_hold_d = b_hold_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_hold_q   <= {DATA_WIDTH{1'b0}};
      b_hold_q   <= {DATA_WIDTH{1'b0}};
    end else begin
      a_rvalid_q <= rd_a_s;
      b_rvalid_q <= rd_b_s;
      a_hold_q   <= a_hold_d;
      b_hold_q   <= b_hold_d;
    end
  end

  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_rdata  = a_rvalid_q ? sram_dout : a_hold_q;
  assign b_rdata  = b_rvalid_q ? sram_dout : b_hold_q;
`endif

endmodule

// File: tb/tb_sram22_dual_req_ctrl.sv
// Directed self-checking bench for sram22_dual_req_ctrl with a behavioural SRAM22 macro.
module tb_sram22_dual_req_ctrl;

  localparam int AW    = 9;
  localparam int DW    = 64;
  localparam int MW    = 8;
  localparam int DEPTH = 512;
`ifdef SRAM22_RDATA_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rstb;
  logic          a_valid, a_ready, a_we, a_rvalid;
  logic [MW-1:0] a_wmask;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_din, a_rdata;
  logic          b_valid, b_ready, b_we, b_rvalid;
  logic [MW-1:0] b_wmask;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_din, b_rdata;
  logic          init_done, sram_rstb, sram_ce, sram_we;
  logic [MW-1:0] sram_wmask;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din, sram_dout;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [DW-1:0] PA = 64'h0123_4567_89AB_CDEF;
  localparam logic [DW-1:0] PB = 64'hFEDC_BA98_7654_3210;

  always #5 clk = ~clk;

  sram22_dual_req_ctrl dut (
    .clk(clk), .rstb(rstb),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_wmask(a_wmask),
    .a_addr(a_addr), .a_din(a_din), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_wmask(b_wmask),
    .b_addr(b_addr), .b_din(b_din), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .init_done(init_done), .sram_rstb(sram_rstb), .sram_ce(sram_ce), .sram_we(sram_we),
    .sram_wmask(sram_wmask), .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
  );

  // Macro model: junk power-up contents, masked writes, registered read data.
  logic [DW-1:0] mem [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 64'hA5A5_5A5A_0000_0000 | 64'(i);
    sram_dout = 64'h0;
    forever begin
      @(posedge clk);
      if (sram_ce) begin
        if (sram_we) begin
          for (int l = 0; l < MW; l++)
            if (sram_wmask[l]) mem[sram_addr][l*8 +: 8] <= sram_din[l*8 +: 8];
        end else begin
          sram_dout <= mem[sram_addr];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit is_b, input logic we, input logic [MW-1:0] mask,
                       input logic [AW-1:0] addr, input logic [DW-1:0] din);
    if (is_b) begin
      b_valid = 1'b1; b_we = we; b_wmask = mask; b_addr = addr; b_din = din;
    end else begin
      a_valid = 1'b1; a_we = we; a_wmask = mask; a_addr = addr; a_din = din;
    end
  endtask

  task automatic idle();
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic do_write(input bit is_b, input logic [AW-1:0] addr, input logic [MW-1:0] mask,
                          input logic [DW-1:0] din, input string tag);
    drive(is_b, 1'b1, mask, addr, din);
    #1;
    check(tag, is_b ? b_ready : a_ready, 1'b1);
    tick();
    idle();
  endtask

  // Samples rvalid for three cycles starting right after acceptance.
  task automatic do_read(input bit is_b, input logic [AW-1:0] addr, input logic [DW-1:0] exp,
                         input string tag);
    logic [2:0]    v;
    logic [DW-1:0] cap;
    cap = 64'hDEAD_DEAD_DEAD_DEAD;
    drive(is_b, 1'b0, 8'h00, addr, 64'h0);
    #1;
    check({tag, "_rdy"}, is_b ? b_ready : a_ready, 1'b1);
    tick();
    idle();
    for (int t = 0; t < 3; t++) begin
      v[t] = is_b ? b_rvalid : a_rvalid;
      if (v[t]) cap = is_b ? b_rdata : a_rdata;
      tick();
    end
    check({tag, "_vld"}, v, 3'(1 << (LAT - 1)));
    check({tag, "_data"}, cap, exp);
    check({tag, "_hold"}, is_b ? b_rdata : a_rdata, exp);
  endtask

  // Called right after rstb rises; checks n fill cycles.
  task automatic fill_sweep(input int n, input string tag);
    int bad;
    bad = 0;
    for (int k = 0; k < n; k++) begin
      #1;
      if (sram_ce !== 1'b1 || sram_we !== 1'b1 || sram_wmask !== 8'hFF ||
          sram_addr !== AW'(k) || sram_din !== 64'h0 || a_ready !== 1'b0 ||
          b_ready !== 1'b0 || init_done !== 1'b0) bad++;
      tick();
    end
    check(tag, 64'(bad), 64'h0);
  endtask

  initial begin
    logic [3:0]    av, bv;
    logic [DW-1:0] acap, bcap;
    logic [11:0]   g;
    logic [2:0]    ga;
    rstb = 1'b0;
    idle();
    a_we = 1'b0; a_wmask = 8'h00; a_addr = 9'h0; a_din = 64'h0;
    b_we = 1'b0; b_wmask = 8'h00; b_addr = 9'h0; b_din = 64'h0;
    drive(1'b0, 1'b0, 8'h00, 9'h005, 64'h0);
    tick(); tick(); tick();
    #1;
    check("rst_a_ready", a_ready, 1'b0);
    check("rst_b_ready", b_ready, 1'b0);
    check("rst_a_rvalid", a_rvalid, 1'b0);
    check("rst_b_rvalid", b_rvalid, 1'b0);
    check("rst_a_rdata", a_rdata, 64'h0);
    check("rst_b_rdata", b_rdata, 64'h0);
    check("rst_init_done", init_done, 1'b0);
    check("rst_sram_ce", sram_ce, 1'b0);
    check("rst_sram_rstb", sram_rstb, 1'b0);
    tick();

    // Zero-fill with A already requesting a read of 0x005.
    rstb = 1'b1;
    fill_sweep(DEPTH, "fill_sweep");
    #1;
    check("init_done_512", init_done, 1'b1);
    check("sram_rstb_hi", sram_rstb, 1'b1);
    check("post_init_addr", sram_addr, 9'h005);
    do_read(1'b0, 9'h005, 64'h0, "rd005");
    check("idle_ce", sram_ce, 1'b0);
    check("idle_we", sram_we, 1'b0);

    // Pointer sits at B here; these writes leave it back at A.
    do_write(1'b1, 9'h020, 8'hFF, PB, "wr_b020");
    do_write(1'b0, 9'h010, 8'hFF, PA, "wr_a010");
    do_write(1'b1, 9'h033, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, "wr_b033");

    // Contention: simultaneous reads.
    drive(1'b0, 1'b0, 8'h00, 9'h010, 64'h0);
    drive(1'b1, 1'b0, 8'h00, 9'h020, 64'h0);
    #1;
    check("cont_a_first", {a_ready, b_ready}, 2'b10);
    check("cont_addr_a", sram_addr, 9'h010);
    tick();
    a_valid = 1'b0;
    #1;
    check("cont_b_second", {a_ready, b_ready}, 2'b01);
    check("cont_addr_b", sram_addr, 9'h020);
    acap = 64'h0; bcap = 64'h0;
    for (int t = 0; t < 4; t++) begin
      av[t] = a_rvalid;
      bv[t] = b_rvalid;
      if (a_rvalid) acap = a_rdata;
      if (b_rvalid) bcap = b_rdata;
      tick();
      if (t == 0) b_valid = 1'b0;
    end
    check("cont_a_lat", av, 4'(1 << (LAT - 1)));
    check("cont_b_lat", bv, 4'(1 << LAT));
    check("cont_a_data", acap, PA);
    check("cont_b_data", bcap, PB);

    // Byte mask plus read-after-write in consecutive cycles.
    do_write(1'b0, 9'h033, 8'h01, 64'h0, "wr_mask");
    do_read(1'b0, 9'h033, 64'hFFFF_FFFF_FFFF_FF00, "rd_mask");

    // Round robin: pointer is at B, a B write hands it to A.
    do_write(1'b1, 9'h040, 8'hFF, 64'h1234, "wr_b040");
    drive(1'b0, 1'b0, 8'h00, 9'h010, 64'h0);
    drive(1'b1, 1'b0, 8'h00, 9'h020, 64'h0);
    g = 12'h0;
    for (int c = 0; c < 6; c++) begin
      #1;
      g = {g[9:0], a_ready, b_ready};
      tick();
    end
    check("rr_alternate", g, 12'b10_01_10_01_10_01);
    b_valid = 1'b0;
    ga = 3'b000;
    for (int c = 0; c < 3; c++) begin
      #1;
      ga = {ga[1:0], a_ready};
      tick();
    end
    check("rr_only_a", ga, 3'b111);
    idle();
    tick(); tick(); tick(); tick();

    // Reset during RUN with a read in flight.
    drive(1'b0, 1'b0, 8'h00, 9'h010, 64'h0);
    #1;
    check("run_rd_rdy", a_ready, 1'b1);
    tick();
    idle();
    rstb = 1'b0;
    tick();
    check("run_rst_rvalid0", a_rvalid, 1'b0);
    tick();
    check("run_rst_rvalid1", a_rvalid, 1'b0);
    check("run_rst_rdata", a_rdata, 64'h0);
    check("run_rst_init_done", init_done, 1'b0);

    // Reset again partway through the fill.
    rstb = 1'b1;
    fill_sweep(200, "fill_part");
    #1;
    check("fill_at_200", sram_addr, 9'd200);
    rstb = 1'b0;
    #1;
    check("midrst_ce", sram_ce, 1'b0);
    tick();
    rstb = 1'b1;
    fill_sweep(DEPTH, "refill_sweep");
    #1;
    check("reinit_done", init_done, 1'b1);
    do_read(1'b1, 9'h010, 64'h0, "rd_refill");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram22_dual_req_ctrl.md
Name: sram22_dual_req_ctrl

Overview:
- Shares one single-port SRAM22 macro (default 512x64, 8-bit write mask) between two requesters, A and B.
- Each requester has a valid/ready request channel and a read-response channel.
- Out of reset, a sequencer zero-fills the whole array before any requester is accepted.
- Round-robin arbitration between A and B; reads complete with fixed latency.

Parameters:
- ADDR_WIDTH, 9, word address width; DEPTH = 1<<ADDR_WIDTH
- DATA_WIDTH, 64, data word width
- WMASK_WIDTH, 8, byte-lane write-enable bits; DATA_WIDTH/WMASK_WIDTH bits per lane

Ports:
- clk  in  1  clock
- rstb  in  1  synchronous active-low reset
- a_valid  in  1  requester A request valid
- a_ready  out  1  requester A request accepted this cycle
- a_we  in  1  A: 1=write, 0=read
- a_wmask  in  WMASK_WIDTH  A byte-lane write mask
- a_addr  in  ADDR_WIDTH  A word address
- a_din  in  DATA_WIDTH  A write data
- a_rvalid  out  1  A read data valid
- a_rdata  out  DATA_WIDTH  A read data
- b_*  same set as a_*, for requester B
- init_done  out  1  zero-fill complete
- sram_rstb  out  1  to macro rstb; equals rstb
- sram_ce, sram_we  out  1  macro controls
- sram_wmask  out  WMASK_WIDTH  macro write mask
- sram_addr  out  ADDR_WIDTH  macro address
- sram_din  out  DATA_WIDTH  macro write data
- sram_dout  in  DATA_WIDTH  macro read data, registered inside macro, valid the cycle after a read issue

Behaviour:
- Reset values (rstb=0 at a clk edge):
  - state=INIT, fill counter=0, rr pointer=A
  - a_ready=b_ready=0, a_rvalid=b_rvalid=0, a_rdata=b_rdata=0, init_done=0
  - sram_ce=0 while rstb=0
- FSM INIT:
  - Each cycle: sram_ce=1, sram_we=1, sram_wmask=all ones, sram_din=0, sram_addr=counter; counter increments.
  - After the write at DEPTH-1, go to RUN.
  - init_done rises the cycle after that last write, i.e. DEPTH cycles after reset release, and stays 1.
  - a_ready=b_ready=0 throughout INIT; requests are held off, not dropped.
- FSM RUN arbitration (combinational):
  - Only one requester valid: it is granted.
  - Both valid: the requester named by the rr pointer is granted.
  - grant_x drives x_ready=1; the sram_* outputs are combinational muxes of the granted requester's signals, with sram_ce=1.
  - No grant: sram_ce=0, sram_we=0.
- rr pointer update: after any grant, the pointer moves to the non-granted requester. With no grant it holds.
- Reads:
  - A granted read (we=0) asserts x_rvalid for exactly one cycle, 1 cycle after acceptance.
  - x_rdata = sram_dout in that cycle; x_rdata holds its value otherwise.
  - Reads have no response backpressure.
- Writes: fire-and-forget, no response. Byte lane i is written iff wmask[i]=1.
- Read after write to the same address, issued in consecutive cycles: the read returns the new data, because the macro commits writes at the edge.
- Both requesters continuously valid: grants alternate A,B,A,B… with a throughput of 1 access per cycle.
- Reset mid-operation:
  - Reset during INIT restarts the fill at address 0.
  - Reset during RUN drops any in-flight read response (rvalid=0) and re-runs the fill.

Optional Feature:
- Macro SRAM22_RDATA_REG_EN.
- Defined: one extra register stage on the read path. x_rvalid and x_rdata appear 2 cycles after acceptance, improving timing from the macro output. The extra stage also clears on reset.
- Undefined: latency 1 as described above.
- Arbitration and INIT behaviour are identical in both cases.

Decomposition:
- Package sram22_ctrl_pkg holds:
  - FSM state enum {INIT, RUN}
  - requester-id enum {REQ_A, REQ_B}
  - default width constants
- Sub-module sram22_rr_arb2: 2-way round-robin arbiter holding the pointer register; inputs valids, outputs one-hot grant.
- The top holds the FSM, fill counter, request mux and read-response tag pipeline.

Test Plan:
- Zero-fill: release reset with a_valid=1 held → a_ready=0 for 512 cycles, init_done=1 at cycle 512, sram_addr sweeps 0..511 with din=0. A read of addr 0x005 then returns 0.
- Contention: after init, A and B both read in the same cycle (A addr 0x010, B addr 0x020) → A granted first, B the next cycle; a_rvalid at +1, b_rvalid at +2, data matches prior writes.
- Byte mask: write 0xFFFF_FFFF_FFFF_FFFF to 0x033 with wmask=0xFF, then 0x0 with wmask=0x01, then read → 0xFFFF_FFFF_FFFF_FF00.
- Round robin: A and B both valid for 6 cycles → grants A,B,A,B,A,B; only A valid → A granted every cycle.
- Mid-init reset: assert rstb=0 at fill address 200, release → fill restarts at 0, init_done again 512 cycles after release.
- Feature: with SRAM22_RDATA_REG_EN, repeat the contention scenario → rvalid latencies become 2 and 3 cycles.
